// File: rtl/restore_state_pkg.sv
// rtl/restore_state_pkg.sv - state-frame layout constants shared by the save and restore blocks
//
// Frame layout (word offset from the frame base):
//   0: {3'b0, aluFlags[3:0], programCounter[8:0]}
//   1: callStackPointer   2: stackPointer
//   3: topOfStack1        4: topOfStack2        5: topOfStack3
//   6: XOR of words 0-5 (only when RESTORE_STATE_CHECKSUM_EN is defined)
package restore_state_pkg;

    localparam int ADDRESS_BITS = 16;
    localparam int DATA_BITS    = 16;

    localparam int PC_BITS   = 9;
    localparam int FLAG_BITS = 4;
    localparam int PC_LSB    = 0;
    localparam int FLAGS_LSB = 9;

    localparam int WORD_PC_FLAGS = 0;
    localparam int WORD_CSP      = 1;
    localparam int WORD_SP       = 2;
    localparam int WORD_TOS1     = 3;
    localparam int WORD_TOS2     = 4;
    localparam int WORD_TOS3     = 5;
    localparam int WORD_CHECKSUM = 6;

    // Words that carry core state; the checksum word is never stored.
    localparam int FIELD_WORDS = 6;

`ifdef RESTORE_STATE_CHECKSUM_EN
    localparam int FRAME_WORDS = 7;
`else
    localparam int FRAME_WORDS = 6;
`endif

    localparam int IDX_BITS = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/restore_state.sv
// rtl/restore_state.sv - reloads a saved processor-state frame from block RAM
//
// Optional feature macro: RESTORE_STATE_CHECKSUM_EN (reads a 7th word and checks
// it against the XOR of words 0-5; checksumError is tied to 0 otherwise).
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, frameBase  begin a restore at frameBase (accepted only when idle)
//   address, rwMode   RAM address (0 when not reading), read select (always 0)
//   dataOut           RAM read data, one cycle after its address
//   busy, finished    restore in progress / one-cycle completion pulse
//   programCounter .. topOfStack3  restored fields, held between restores
//   checksumError     frame checksum mismatch, valid with finished
module restore_state
    import restore_state_pkg::*;
#(
    parameter int addrBits = ADDRESS_BITS,
    parameter int dataBits = DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [addrBits-1:0]  frameBase,
    output logic [addrBits-1:0]  address,
    output logic                 rwMode,
    input  logic [dataBits-1:0]  dataOut,
    output logic                 busy,
    output logic                 finished,
    output logic [PC_BITS-1:0]   programCounter,
    output logic [FLAG_BITS-1:0] aluFlags,
    output logic [addrBits-1:0]  callStackPointer,
    output logic [addrBits-1:0]  stackPointer,
    output logic [dataBits-1:0]  topOfStack1,
    output logic [dataBits-1:0]  topOfStack2,
    output logic [dataBits-1:0]  topOfStack3,
    output logic                 checksumError
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(FRAME_WORDS - 1);

    logic [1:0]           state_q, state_d;
    logic [addrBits-1:0]  base_q, base_d;
    logic [IDX_BITS-1:0]  idx_q, idx_d;
    logic [dataBits-1:0]  words_q [FIELD_WORDS];
    logic [dataBits-1:0]  words_d [FIELD_WORDS];
    logic                 finished_q, finished_d;

    logic [PC_BITS-1:0]   pc_q, pc_d;
    logic [FLAG_BITS-1:0] flags_q, flags_d;
    logic [addrBits-1:0]  csp_q, csp_d;
    logic [addrBits-1:0]  sp_q, sp_d;
    logic [dataBits-1:0]  tos1_q, tos1_d;
    logic [dataBits-1:0]  tos2_q, tos2_d;
    logic [dataBits-1:0]  tos3_q, tos3_d;

    logic                 capture;
    logic                 commit;
    logic [IDX_BITS-1:0]  cap_idx;

`ifdef RESTORE_STATE_CHECKSUM_EN
    logic [dataBits-1:0]  xor_q, xor_d;
    logic                 cksum_err_q, cksum_err_d;
`endif

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        idx_d      = idx_q;
        words_d    = words_q;
        finished_d = 1'b0;
        capture    = 1'b0;
        commit     = 1'b0;
        // Read data lags the address by one cycle, so the word landing now
        // belongs to the previous index.
        cap_idx    = idx_q - IDX_BITS'(1);
        pc_d       = pc_q;
        flags_d    = flags_q;
        csp_d      = csp_q;
        sp_d       = sp_q;
        tos1_d     = tos1_q;
        tos2_d     = tos2_q;
        tos3_d     = tos3_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = frameBase;
                    idx_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                idx_d   = idx_q + IDX_BITS'(1);
                capture = (idx_q != '0);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                capture    = 1'b1;
                cap_idx    = LAST_IDX;
                commit     = 1'b1;
                finished_d = 1'b1;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            for (int i = 0; i < FIELD_WORDS; i++) begin
                if (cap_idx == IDX_BITS'(i)) begin
                    words_d[i] = dataOut;
                end
            end
        end

        // Commit from words_d so the word arriving in DRAIN is included and
        // every field changes on the same edge.
        if (commit) begin
            pc_d    = words_d[WORD_PC_FLAGS][PC_LSB +: PC_BITS];
            flags_d = words_d[WORD_PC_FLAGS][FLAGS_LSB +: FLAG_BITS];
            csp_d   = addrBits'(words_d[WORD_CSP]);
            sp_d    = addrBits'(words_d[WORD_SP]);
            tos1_d  = words_d[WORD_TOS1];
            tos2_d  = words_d[WORD_TOS2];
            tos3_d  = words_d[WORD_TOS3];
        end
    end

`ifdef RESTORE_STATE_CHECKSUM_EN
    always_comb begin
        xor_d       = xor_q;
        cksum_err_d = 1'b0;
        if (state_q == ST_IDLE && start) begin
            xor_d = '0;
        end else if (capture && cap_idx < IDX_BITS'(FIELD_WORDS)) begin
            xor_d = xor_q ^ dataOut;
        end
        // In DRAIN the arriving word is the checksum and xor_q covers words 0-5.
        if (state_q == ST_DRAIN) begin
            cksum_err_d = (xor_q != dataOut);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xor_q       <= '0;
            cksum_err_q <= 1'b0;
        end else begin
            xor_q       <= xor_d;
            cksum_err_q <= cksum_err_d;
        end
    end

    assign checksumError = cksum_err_q;
`else
    assign checksumError = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            idx_q      <= '0;
            words_q    <= '{default: '0};
            finished_q <= 1'b0;
            pc_q       <= '0;
            flags_q    <= '0;
            csp_q      <= '0;
            sp_q       <= '0;
            tos1_q     <= '0;
            tos2_q     <= '0;
            tos3_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            words_q    <= words_d;
            finished_q <= finished_d;
            pc_q       <= pc_d;
            flags_q    <= flags_d;
            csp_q      <= csp_d;
            sp_q       <= sp_d;
            tos1_q     <= tos1_d;
            tos2_q     <= tos2_d;
            tos3_q     <= tos3_d;
        end
    end

    // Addition wraps modulo 2^addrBits so a frame may straddle the top of memory.
    assign address          = (state_q == ST_READ) ? base_q + addrBits'(idx_q) : '0;
    assign rwMode           = 1'b0;
    assign busy             = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign finished         = finished_q;
    assign programCounter   = pc_q;
    assign aluFlags         = flags_q;
    assign callStackPointer = csp_q;
    assign stackPointer     = sp_q;
    assign topOfStack1      = tos1_q;
    assign topOfStack2      = tos2_q;
    assign topOfStack3      = tos3_q;

endmodule
